// File: rtl/c1_bus_arbiter.sv
// Two-requester arbiter for the shared C1 CPU-to-cache bus: round-robin grant, two-cycle
// address phase, split 16-bit data halves, response wait with timeout, and a turnaround cycle.
package c1_bus_pkg;
    localparam logic [2:0] NONE_C1             = 3'd0;
    localparam logic [2:0] READ8               = 3'd1;
    localparam logic [2:0] READ16              = 3'd2;
    localparam logic [2:0] READ32              = 3'd3;
    localparam logic [2:0] WRITE32_OR_RESPONSE = 3'd4;
endpackage

module c1_bus_arbiter #(
    parameter int TAG_W   = 10,
    parameter int SET_W   = 5,
    parameter int OFF_W   = 4,
    parameter int DATA_W  = 16,
    parameter int CTR_W   = 3,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               req_valid,
    input  logic [2*CTR_W-1:0]       req_cmd,
    input  logic [2*TAG_W-1:0]       req_tag,
    input  logic [2*SET_W-1:0]       req_set,
    input  logic [2*OFF_W-1:0]       req_off,
    input  logic [63:0]              req_wdata,
    output logic [1:0]               req_done,
    output logic                     req_err,
    output logic [31:0]              rdata,
    output logic                     grant,
    output logic                     busy,
    output logic [TAG_W+SET_W-1:0]   a1_out,
    output logic                     a1_oe,
    output logic [DATA_W-1:0]        d1_out,
    output logic                     d1_oe,
    output logic [CTR_W-1:0]         c1_out,
    output logic                     c1_oe,
    input  logic [DATA_W-1:0]        d1_in,
    input  logic [CTR_W-1:0]         c1_in
);
    localparam int ADDR_W = TAG_W + SET_W;
    localparam int CNT_W  = $clog2(TIMEOUT + 1);

    localparam logic [CTR_W-1:0] C_NONE   = CTR_W'(c1_bus_pkg::NONE_C1);
    localparam logic [CTR_W-1:0] C_READ8  = CTR_W'(c1_bus_pkg::READ8);
    localparam logic [CTR_W-1:0] C_READ16 = CTR_W'(c1_bus_pkg::READ16);
    localparam logic [CTR_W-1:0] C_READ32 = CTR_W'(c1_bus_pkg::READ32);
    localparam logic [CTR_W-1:0] C_WRITE  = CTR_W'(c1_bus_pkg::WRITE32_OR_RESPONSE);

    typedef enum logic [2:0] {S_IDLE, S_ADDR1, S_ADDR2, S_WAIT, S_DATA2, S_TURN} state_t;

    state_t             state;
    logic               rr_ptr;
    logic [CTR_W-1:0]   cmd_q;
    logic [OFF_W-1:0]   off_q;
    logic [31:0]        wdata_q;
    logic [CNT_W-1:0]   cnt;

    logic               win;
    logic [CTR_W-1:0]   sel_cmd;
    logic [TAG_W-1:0]   sel_tag;
    logic [SET_W-1:0]   sel_set;
    logic [OFF_W-1:0]   sel_off;
    logic [31:0]        sel_wdata;
    logic               sel_ok, sel_wr, cmd_ok, cmd_wr;

    function automatic logic supported(input logic [CTR_W-1:0] c);
        return c inside {C_READ8, C_READ16, C_READ32, C_WRITE};
    endfunction

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        win = rr_ptr;
        if (req_valid == 2'b01)
            win = 1'b0;
        else if (req_valid == 2'b10)
            win = 1'b1;
    end

    assign sel_cmd   = win ? req_cmd[2*CTR_W-1 -: CTR_W]   : req_cmd[CTR_W-1:0];
    assign sel_tag   = win ? req_tag[2*TAG_W-1 -: TAG_W]   : req_tag[TAG_W-1:0];
    assign sel_set   = win ? req_set[2*SET_W-1 -: SET_W]   : req_set[SET_W-1:0];
    assign sel_off   = win ? req_off[2*OFF_W-1 -: OFF_W]   : req_off[OFF_W-1:0];
    assign sel_wdata = win ? req_wdata[63:32]              : req_wdata[31:0];
    assign sel_ok    = supported(sel_cmd);
    assign sel_wr    = (sel_cmd == C_WRITE);
    assign cmd_ok    = supported(cmd_q);
    assign cmd_wr    = (cmd_q == C_WRITE);

    // Bus outputs are registered: each state's drive values are loaded on the edge that enters it.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            rr_ptr   <= 1'b0;
            cmd_q    <= '0;
            off_q    <= '0;
            wdata_q  <= '0;
            cnt      <= '0;
            req_done <= '0;
            req_err  <= 1'b0;
            rdata    <= '0;
            grant    <= 1'b0;
            busy     <= 1'b0;
            a1_out   <= '0;
            a1_oe    <= 1'b0;
            d1_out   <= '0;
            d1_oe    <= 1'b0;
            c1_out   <= '0;
            c1_oe    <= 1'b0;
        end else begin
            req_done <= '0;
            req_err  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (|req_valid) begin
                        state   <= S_ADDR1;
                        busy    <= 1'b1;
                        grant   <= win;
                        if (&req_valid)
                            rr_ptr <= ~rr_ptr;
                        cmd_q   <= sel_cmd;
                        off_q   <= sel_off;
                        wdata_q <= sel_wdata;
                        c1_oe   <= sel_ok;
                        a1_oe   <= sel_ok;
                        d1_oe   <= sel_ok && sel_wr;
                        c1_out  <= sel_ok ? sel_cmd : C_NONE;
                        a1_out  <= sel_ok ? {sel_tag, sel_set} : '0;
                        d1_out  <= (sel_ok && sel_wr) ? DATA_W'(sel_wdata[15:0]) : '0;
                    end
                end
                S_ADDR1: begin
                    state <= S_ADDR2;
                    if (cmd_ok)
                        a1_out <= ADDR_W'(off_q);
                    if (cmd_wr)
                        d1_out <= DATA_W'(wdata_q[31:16]);
                end
                S_ADDR2: begin
                    a1_oe  <= 1'b0;
                    a1_out <= '0;
                    d1_oe  <= 1'b0;
                    d1_out <= '0;
                    if (cmd_ok) begin
                        state  <= S_WAIT;
                        c1_oe  <= 1'b0;
                        c1_out <= '0;
                    end else begin
                        // Unsupported commands never touch the bus and finish with an error.
                        state           <= S_TURN;
                        c1_oe           <= 1'b1;
                        c1_out          <= C_NONE;
                        req_done[grant] <= 1'b1;
                        req_err         <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (c1_in == C_WRITE) begin
                        if (cmd_q == C_READ32) begin
                            rdata[15:0] <= d1_in[15:0];
                            state       <= S_DATA2;
                        end else begin
                            if (cmd_q == C_READ8)
                                rdata <= 32'(d1_in[7:0]);
                            else if (cmd_q == C_READ16)
                                rdata <= 32'(d1_in);
                            state           <= S_TURN;
                            c1_oe           <= 1'b1;
                            c1_out          <= C_NONE;
                            req_done[grant] <= 1'b1;
                        end
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        state           <= S_TURN;
                        c1_oe           <= 1'b1;
                        c1_out          <= C_NONE;
                        req_done[grant] <= 1'b1;
                        req_err         <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA2: begin
                    rdata[31:16]    <= d1_in[15:0];
                    state           <= S_TURN;
                    c1_oe           <= 1'b1;
                    c1_out          <= C_NONE;
                    req_done[grant] <= 1'b1;
                end
                S_TURN: begin
                    state  <= S_IDLE;
                    busy   <= 1'b0;
                    cnt    <= '0;
                    c1_oe  <= 1'b0;
                    c1_out <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_c1_bus_arbiter.sv
// Scoreboard bench for c1_bus_arbiter: stimulus tasks play requesters and cache, a monitor
// checks every done pulse against queued expectations.
module tb_c1_bus_arbiter;
    import c1_bus_pkg::*;

    localparam int TAG_W = 10, SET_W = 5, OFF_W = 4, DATA_W = 16, CTR_W = 3, TIMEOUT = 8;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [1:0]             req_valid;
    logic [2*CTR_W-1:0]     req_cmd;
    logic [2*TAG_W-1:0]     req_tag;
    logic [2*SET_W-1:0]     req_set;
    logic [2*OFF_W-1:0]     req_off;
    logic [63:0]            req_wdata;
    logic [1:0]             req_done;
    logic                   req_err;
    logic [31:0]            rdata;
    logic                   grant, busy;
    logic [TAG_W+SET_W-1:0] a1_out;
    logic                   a1_oe;
    logic [DATA_W-1:0]      d1_out;
    logic                   d1_oe;
    logic [CTR_W-1:0]       c1_out;
    logic                   c1_oe;
    logic [DATA_W-1:0]      d1_in;
    logic [CTR_W-1:0]       c1_in;

    c1_bus_arbiter #(
        .TAG_W(TAG_W), .SET_W(SET_W), .OFF_W(OFF_W),
        .DATA_W(DATA_W), .CTR_W(CTR_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_cmd(req_cmd),
        .req_tag(req_tag), .req_set(req_set), .req_off(req_off), .req_wdata(req_wdata),
        .req_done(req_done), .req_err(req_err), .rdata(rdata), .grant(grant), .busy(busy),
        .a1_out(a1_out), .a1_oe(a1_oe), .d1_out(d1_out), .d1_oe(d1_oe),
        .c1_out(c1_out), .c1_oe(c1_oe), .d1_in(d1_in), .c1_in(c1_in)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          req;
        bit          err;
        logic [31:0] rdata;
        int          lat;   // accept-to-done cycles; 0 = not checked
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int r, input bit err, input logic [31:0] rd, input int lat);
        exp_t e;
        e.req = r; e.err = err; e.rdata = rd; e.lat = lat;
        sb.push_back(e);
    endtask

    // Monitor: pops one expectation per done pulse; latency counts from the ADDR1 cycle.
    initial begin
        int   start_cyc = 0;
        logic busy_q = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (busy === 1'b1 && busy_q !== 1'b1)
                start_cyc = cyc;
            busy_q = busy;
            if (|req_done === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'(req_done), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("done_bit", 64'(req_done), 64'(2'b01 << e.req));
                    check("done_grant", 64'(grant), 64'(e.req));
                    check("done_err", 64'(req_err), 64'(e.err));
                    check("done_rdata", 64'(rdata), 64'(e.rdata));
                    if (e.lat > 0)
                        check("latency", 64'(cyc - start_cyc + 1), 64'(e.lat));
                end
            end
        end
    end

    task automatic set_req(input int r, input logic [2:0] cmd, input logic [TAG_W-1:0] tag,
                           input logic [SET_W-1:0] set, input logic [OFF_W-1:0] off,
                           input logic [31:0] wd);
        req_cmd[r*CTR_W +: CTR_W] = cmd;
        req_tag[r*TAG_W +: TAG_W] = tag;
        req_set[r*SET_W +: SET_W] = set;
        req_off[r*OFF_W +: OFF_W] = off;
        req_wdata[r*32 +: 32]     = wd;
    endtask

    task automatic wait_busy(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy === 1'b1) begin
                ok = 1'b1;
                return;
            end
        end
        check("busy_rise", 64'(busy), 64'd1);
    endtask

    // Plays the cache for one transaction; rsp < 0 means never respond (timeout).
    task automatic bus_txn(input int r, input logic [2:0] cmd, input logic [TAG_W-1:0] tag,
                           input logic [SET_W-1:0] set, input logic [OFF_W-1:0] off,
                           input logic [31:0] wd, input int rsp, input logic [15:0] b0,
                           input logic [15:0] b1, input logic [1:0] drop);
        bit ok;
        bit wr;
        wr = (cmd == WRITE32_OR_RESPONSE);
        wait_busy(ok);
        if (!ok) return;
        check("addr1_grant", 64'(grant), 64'(r));
        check("addr1_oe", {61'd0, a1_oe, d1_oe, c1_oe}, {61'd0, 1'b1, wr, 1'b1});
        check("addr1_c1", 64'(c1_out), 64'(cmd));
        check("addr1_a1", 64'(a1_out), 64'({tag, set}));
        if (wr) check("addr1_d1", 64'(d1_out), 64'(wd[15:0]));
        @(negedge clk);
        check("addr2_c1", 64'(c1_out), 64'(cmd));
        check("addr2_a1", 64'(a1_out), 64'(off));
        if (wr) check("addr2_d1", 64'(d1_out), 64'(wd[31:16]));
        @(negedge clk);
        check("wait_oe", {61'd0, a1_oe, d1_oe, c1_oe}, 64'd0);
        if (rsp >= 0) begin
            repeat (rsp) @(negedge clk);
            c1_in = WRITE32_OR_RESPONSE;
            d1_in = b0;
            @(negedge clk);
            c1_in = NONE_C1;
            d1_in = '0;
            if (cmd == READ32) begin
                d1_in = b1;
                @(negedge clk);
                d1_in = '0;
            end
        end else begin
            repeat (TIMEOUT) @(negedge clk);
        end
        check("turn_oe", {61'd0, a1_oe, d1_oe, c1_oe}, 64'd1);
        check("turn_c1", 64'(c1_out), 64'(NONE_C1));
        req_valid = req_valid & ~drop;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        reset = 1'b0; req_valid = '0; req_cmd = '0; req_tag = '0; req_set = '0;
        req_off = '0; req_wdata = '0; d1_in = '0; c1_in = NONE_C1;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ctrl", {59'd0, req_done, req_err, grant, busy},  64'd0);
        check("rst_oe", {61'd0, a1_oe, d1_oe, c1_oe}, 64'd0);
        check("rst_outs", {a1_out, d1_out, c1_out}, 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        reset = 1'b0;

        // Single READ8 from req0, response after two idle WAIT cycles.
        set_req(0, READ8, 10'd3, 5'd5, 4'd7, 32'd0);
        req_valid = 2'b01;
        push_exp(0, 1'b0, 32'h0000_00A5, 6);
        bus_txn(0, READ8, 10'd3, 5'd5, 4'd7, 32'd0, 2, 16'h00A5, 16'h0, 2'b01);

        // WRITE32 from req1, immediate response; rdata keeps its previous value.
        set_req(1, WRITE32_OR_RESPONSE, 10'h2A1, 5'd17, 4'd2, 32'hDEAD_BEEF);
        req_valid = 2'b10;
        push_exp(1, 1'b0, 32'h0000_00A5, 4);
        bus_txn(1, WRITE32_OR_RESPONSE, 10'h2A1, 5'd17, 4'd2, 32'hDEAD_BEEF, 0, 16'h0, 16'h0, 2'b10);

        // READ32 from req0: two data beats.
        set_req(0, READ32, 10'h3FF, 5'd31, 4'd15, 32'd0);
        req_valid = 2'b01;
        push_exp(0, 1'b0, 32'h1234_5678, 6);
        bus_txn(0, READ32, 10'h3FF, 5'd31, 4'd15, 32'd0, 1, 16'h5678, 16'h1234, 2'b01);

        // READ16 from req1.
        set_req(1, READ16, 10'd0, 5'd0, 4'd0, 32'd0);
        req_valid = 2'b10;
        push_exp(1, 1'b0, 32'h0000_BEEF, 7);
        bus_txn(1, READ16, 10'd0, 5'd0, 4'd0, 32'd0, 3, 16'hBEEF, 16'h0, 2'b10);

        // No response: abort after TIMEOUT WAIT cycles with rdata untouched.
        set_req(0, READ16, 10'd9, 5'd9, 4'd9, 32'd0);
        req_valid = 2'b01;
        push_exp(0, 1'b1, 32'h0000_BEEF, 3 + TIMEOUT);
        bus_txn(0, READ16, 10'd9, 5'd9, 4'd9, 32'd0, -1, 16'h0, 16'h0, 2'b01);
        @(negedge clk);
        check("released_oe", {61'd0, a1_oe, d1_oe, c1_oe}, 64'd0);
        check("released_busy", 64'(busy), 64'd0);

        // Unsupported command: no bus drive, error completion.
        set_req(1, NONE_C1, 10'd1, 5'd1, 4'd1, 32'd0);
        req_valid = 2'b10;
        push_exp(1, 1'b1, 32'h0000_BEEF, 0);
        wait_busy(ok);
        check("bad_addr1_oe", {61'd0, a1_oe, d1_oe, c1_oe}, 64'd0);
        @(negedge clk);
        check("bad_addr2_oe", {61'd0, a1_oe, d1_oe, c1_oe}, 64'd0);
        @(negedge clk);
        check("bad_turn_c1oe", 64'(c1_oe), 64'd1);
        req_valid = 2'b00;

        // Both requesters held valid: grants alternate 0,1,0,1.
        set_req(0, READ16, 10'd1, 5'd1, 4'd0, 32'd0);
        set_req(1, READ8, 10'd2, 5'd2, 4'd1, 32'd0);
        @(negedge clk);
        req_valid = 2'b11;
        push_exp(0, 1'b0, 32'h0000_1100, 4);
        push_exp(1, 1'b0, 32'h0000_0001, 4);
        push_exp(0, 1'b0, 32'h0000_3302, 4);
        push_exp(1, 1'b0, 32'h0000_0003, 4);
        bus_txn(0, READ16, 10'd1, 5'd1, 4'd0, 32'd0, 0, 16'h1100, 16'h0, 2'b00);
        bus_txn(1, READ8,  10'd2, 5'd2, 4'd1, 32'd0, 0, 16'h2201, 16'h0, 2'b00);
        bus_txn(0, READ16, 10'd1, 5'd1, 4'd0, 32'd0, 0, 16'h3302, 16'h0, 2'b00);
        bus_txn(1, READ8,  10'd2, 5'd2, 4'd1, 32'd0, 0, 16'h4403, 16'h0, 2'b11);

        // Leave rr_ptr pointing at req1, then reset while req1 sits in WAIT.
        set_req(0, READ16, 10'd4, 5'd4, 4'd4, 32'd0);
        set_req(1, READ16, 10'd6, 5'd6, 4'd6, 32'd0);
        @(negedge clk);
        req_valid = 2'b11;
        push_exp(0, 1'b0, 32'h0000_5A5A, 4);
        bus_txn(0, READ16, 10'd4, 5'd4, 4'd4, 32'd0, 0, 16'h5A5A, 16'h0, 2'b01);
        wait_busy(ok);
        check("pre_rst_grant", 64'(grant), 64'd1);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_oe", {61'd0, a1_oe, d1_oe, c1_oe}, 64'd0);
        check("midrst_ctrl", {59'd0, req_done, req_err, grant, busy}, 64'd0);
        check("midrst_rdata", 64'(rdata), 64'd0);
        @(negedge clk);
        check("rst_no_done", 64'(req_done), 64'd0);
        reset = 1'b0;
        req_valid = 2'b11;
        push_exp(0, 1'b0, 32'h0000_0F0F, 5);
        bus_txn(0, READ16, 10'd4, 5'd4, 4'd4, 32'd0, 1, 16'h0F0F, 16'h0, 2'b11);

        repeat (4) @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
